key_debounce8: RTL and testbench
================================

# key_debounce8

Eight-channel push-button conditioner that sits directly upstream of the 74HC148 priority encoder stage. It takes raw, bouncing, active-low board keys and synchronises and debounces each one independently. It then presents clean active-low request lines `I[7:0]` and an active-low enable `EI` in the exact format the encoder consumes, plus per-key press pulses and an any-key flag for control logic.

## Interface
Parameters:
- `DEB_CYCLES`, default 250000: consecutive stable cycles required to accept a key change (5 ms at 50 MHz). Legal range is 2 ≤ `DEB_CYCLES` < 2^`CNT_W`.
- `CNT_W`, default 18: width of each per-key debounce counter.

Ports:
- `CLK`: in, 1. Single system clock; all state is on its rising edge.
- `RST_N`: in, 1. Asynchronous, active-low reset.
- `KEY`: in, 8. Raw key inputs, active-low (0 = pressed), asynchronous to `CLK`.
- `EN`: in, 1. Encoder enable request, active-high, synchronous.
- `I`: out, 8. Debounced key lines, active-low; feeds the encoder `I[7:0]`.
- `EI`: out, 1. Active-low encoder enable, registered.
- `PRESS`: out, 8. One-cycle pulse per key on each accepted press.
- `ANY`: out, 1. 1 while any debounced key is pressed and `EN` = 1.

## Operation
Reset values: sync flops 1, stable state `S[7:0]` = 8'hFF, counters 0, `I` = 8'hFF, `EI` = 1, `PRESS` = 0, `ANY` = 0.

Per-key path (k = 0..7), all channels identical and independent:
- **Synchroniser:** two flops, `KEY[k]` → `q1[k]` → `q2[k]`.
- **Debounce counter `C[k]`, each cycle:**
  - if `q2[k]` == `S[k]`: `C[k]` ← 0.
  - else if `C[k]` == `DEB_CYCLES`−1: `S[k]` ← `q2[k]`, `C[k]` ← 0 (change accepted).
  - else: `C[k]` ← `C[k]`+1.
- Any single cycle in which `q2[k]` returns to `S[k]` (a bounce) clears `C[k]`. A glitch shorter than `DEB_CYCLES` cycles never reaches `S`.
- The counter never exceeds `DEB_CYCLES`−1; there is no wrap-around.
- **`PRESS[k]`:** registered. It is 1 for exactly the cycle following an accepted 1→0 change, i.e. coincident with the first cycle `I[k]` = 0. An accepted release (0→1) produces no pulse.

Output gating (registered, one stage):
- `I` ← `EN` ? `S_next` : 8'hFF.
- `EI` ← ~`EN`.
- `ANY` ← `EN` & ~&`S_next`.
- `PRESS` is also masked by `EN`.
- Debounce counters keep running while `EN` = 0. When `EN` rises, `I` shows current key state on the next cycle with no re-debounce.

Simultaneous changes on several keys are accepted independently, each on its own count. Priority resolution is the downstream encoder's job, not this block's.

Reset asserted mid-count forces all state to the reset values immediately. Partial counts are discarded. After release, held keys need the full sync + `DEB_CYCLES` to appear.

## Timing
- Let t0 be the first `CLK` edge that samples a new, steady `KEY[k]` level.
  - `q2[k]` changes at edge t0+1.
  - `S[k]` and `I[k]` update at edge t0+1+`DEB_CYCLES`.
  - `PRESS[k]` is high for exactly the cycle following edge t0+1+`DEB_CYCLES`.
- `EN` → `EI` / `I` gating latency: 1 cycle.
- `RST_N` assertion affects outputs asynchronously. Deassertion is expected to be synchronised externally to `CLK`.
- No combinational path from any input to any output.

## Test plan
Bench uses `DEB_CYCLES` = 4, `CNT_W` = 3.
- **Reset:** `RST_N` = 0 with `KEY` = 8'h00 → `I` = 8'hFF, `EI` = 1, `PRESS` = 0, `ANY` = 0. Release reset with `EN` = 1 and `KEY` steady 8'hFE → `I` = 8'hFE exactly 5 edges after the first sampling edge, `PRESS` = 8'h01 for one cycle, `ANY` = 1.
- **Bounce rejection:** `KEY[3]` toggles 0/1/0 every 3 cycles for 30 cycles, then holds 1 → `I` stays 8'hFF throughout, `PRESS` never asserts.
- **Clean press/release:** `KEY[7]` held 0 for 20 cycles, then 1 → `I[7]` = 0 after 5 cycles with a single `PRESS[7]` pulse; `I[7]` = 1 five cycles after release, with no pulse on release.
- **Simultaneous keys:** `KEY[2]` and `KEY[5]` both fall on the same edge → `I` = 8'hDB on the same cycle, `PRESS` = 8'h24 for one cycle.
- **Enable gating:** with `EN` = 0, hold `KEY[1]` = 0 for 10 cycles → `I` = 8'hFF, `EI` = 1, `ANY` = 0. Raise `EN` → next cycle `I` = 8'hFD, `EI` = 0, `ANY` = 1, `PRESS` = 0.
- **Reset mid-count:** `KEY[0]` falls, then `RST_N` pulses low 2 cycles into the count → outputs return to reset values immediately. With the key still held, `I[0]` = 0 only 5 edges after the first post-reset sampling edge.

Source files
------------

// File: rtl/key_debounce8.sv
// key_debounce8: synchronise and debounce eight active-low keys for a 74HC148 encoder
//   CLK, RST_N : clock, asynchronous active-low reset
//   KEY[7:0]   : raw bouncing keys, active-low, asynchronous to CLK
//   EN         : encoder enable request, active-high
//   I[7:0]     : debounced key lines, active-low, forced high while EN = 0
//   EI         : registered active-low encoder enable
//   PRESS[7:0] : one-cycle pulse per accepted press, coincident with I[k] falling
//   ANY        : any debounced key pressed while EN = 1
module key_debounce8 #(
  parameter int DEB_CYCLES = 250000,
  parameter int CNT_W = 18
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] KEY,
  input  logic       EN,
  output logic [7:0] I,
  output logic       EI,
  output logic [7:0] PRESS,
  output logic       ANY
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);
  logic [7:0] q1, q2, s, s_next;
  for (genvar g = 0; g < 8; g++) begin : ch
    logic [CNT_W-1:0] c;
    // a change is accepted on the cycle its count saturates; any return to s restarts it
    assign s_next[g] = (q2[g] != s[g] && c == LAST) ? q2[g] : s[g];
    always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) c <= '0;
      else c <= (q2[g] == s[g] || c == LAST) ? '0 : c + 1'b1;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      q1 <= '1;
      q2 <= '1;
      s <= '1;
      I <= '1;
      EI <= 1'b1;
      PRESS <= '0;
      ANY <= 1'b0;
    end else begin
      q1 <= KEY;
      q2 <= q1;
      s <= s_next;
      I <= EN ? s_next : '1;
      EI <= ~EN;
      PRESS <= EN ? s & ~s_next : '0;
      ANY <= EN & ~&s_next;
    end
endmodule

// File: tb/tb_key_debounce8.sv
// tb_key_debounce8: scoreboard bench for key_debounce8 against a window-based key model
module tb_key_debounce8;
  localparam int DEB = 4;
  logic clk = 0, rst_n = 0, en = 1;
  logic [7:0] key = 8'h00;
  logic [7:0] i_o, press_o;
  logic ei_o, any_o;
  int total = 0, bad = 0;

  key_debounce8 #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
    .CLK(clk), .RST_N(rst_n), .KEY(key), .EN(en),
    .I(i_o), .EI(ei_o), .PRESS(press_o), .ANY(any_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] i;
    logic       ei;
    logic [7:0] press;
    logic       any;
  } exp_t;

  exp_t sb[$];
  logic [7:0] hist[$];
  logic [7:0] ms = 8'hFF;

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, x, $time);
    end
  endtask

  // A key's debounced level flips once the synchronised level (two samples late)
  // has been the opposite level for the last DEB consecutive cycles.
  always @(posedge clk) begin
    exp_t e;
    logic [7:0] sn;
    logic st;
    int idx;
    if (!rst_n) begin
      hist = {};
      ms = 8'hFF;
      e.i = 8'hFF;
      e.ei = 1'b1;
      e.press = 8'h00;
      e.any = 1'b0;
    end else begin
      hist.push_back(key);
      if (hist.size() > 8) void'(hist.pop_front());
      sn = ms;
      for (int k = 0; k < 8; k++) begin
        st = 1'b1;
        for (int j = 0; j < DEB; j++) begin
          idx = hist.size() - 3 - j;
          if ((idx >= 0 ? hist[idx][k] : 1'b1) == ms[k]) st = 1'b0;
        end
        if (st) sn[k] = ~ms[k];
      end
      e.i = en ? sn : 8'hFF;
      e.ei = ~en;
      e.press = en ? (ms & ~sn) : 8'h00;
      e.any = en & ~&sn;
      ms = sn;
    end
    sb.push_back(e);
  end

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty got=0 want=1 t=%0t", $time);
    end else begin
      e = sb.pop_front();
      chk("I", i_o, e.i);
      chk("EI", {7'b0, ei_o}, {7'b0, e.ei});
      chk("PRESS", press_o, e.press);
      chk("ANY", {7'b0, any_o}, {7'b0, e.any});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_I"}, i_o, 8'hFF);
    chk({n, "_EI"}, {7'b0, ei_o}, 8'h01);
    chk({n, "_PRESS"}, press_o, 8'h00);
    chk({n, "_ANY"}, {7'b0, any_o}, 8'h00);
  endtask

  initial begin
    cyc(3);
    chk_reset("rst");
    key = 8'hFE;
    rst_n = 1;
    cyc(12);
    chk("held_I", i_o, 8'hFE);
    key = 8'hFF;
    cyc(10);
    for (int n = 0; n < 10; n++) begin
      key = n[0] ? 8'hFF : 8'hF7;
      cyc(3);
    end
    key = 8'hFF;
    cyc(10);
    key = 8'h7F;
    cyc(20);
    key = 8'hFF;
    cyc(10);
    key = 8'hDB;
    cyc(10);
    key = 8'hFF;
    cyc(10);
    en = 0;
    key = 8'hFD;
    cyc(10);
    en = 1;
    cyc(3);
    key = 8'hFF;
    cyc(10);
    key = 8'hFE;
    cyc(4);
    rst_n = 0;
    #1;
    chk_reset("midrst");
    cyc(2);
    rst_n = 1;
    cyc(10);
    key = 8'hFF;
    cyc(10);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) key[$urandom_range(0, 7)] = ~key[$urandom_range(0, 7)];
      if ($urandom_range(0, 6) == 0) key = $urandom_range(0, 1) ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 99) == 0) en = ~en;
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 0;
        cyc(2);
        rst_n = 1;
      end
      cyc(1);
    end
    cyc(2);
    @(posedge clk);
    #2;
    chk("sb_drain", 8'(sb.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
